// File: rtl/jump_gen.sv
// Debounced one-shot jump window generator with post-jump cooldown.
// Optional re-trigger in RISE enabled by defining JUMP_GEN_DOUBLE_JUMP_EN.
module jump_gen #(
    parameter int DB_LEN    = 4,
    parameter int JUMP_TIME = 40,
    parameter int COOL_TIME = 8,
    parameter int CW        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn,
    input  logic       game_en,
    output logic       jump,
    output logic       busy,
    output logic [7:0] jump_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        COOL
    } state_t;

    localparam logic [CW-1:0] J_LAST = CW'(JUMP_TIME - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COOL_TIME - 1);

    logic              sync1;
    logic              sync2;
    logic [DB_LEN-1:0] sh;
    logic              btn_db;
    logic              btn_db_q;
    logic              press;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic              inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sh       <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            sh       <= {sh[DB_LEN-2:0], sync2};
            btn_db_q <= btn_db;
            if (&sh)
                btn_db <= 1'b1;
            else if (~|sh)
                btn_db <= 1'b0;
        end
    end

    assign press = btn_db & ~btn_db_q;

`ifdef JUMP_GEN_DOUBLE_JUMP_EN
    logic dbl;
    logic dbl_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dbl <= 1'b0;
        else
            dbl <= dbl_n;
    end
`endif

    // Priority: abort, then tick expiry, then press.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        inc     = 1'b0;
`ifdef JUMP_GEN_DOUBLE_JUMP_EN
        dbl_n   = dbl;
`endif
        if (!game_en) begin
            state_n = IDLE;
            cnt_n   = '0;
`ifdef JUMP_GEN_DOUBLE_JUMP_EN
            dbl_n   = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef JUMP_GEN_DOUBLE_JUMP_EN
                    dbl_n = 1'b0;
`endif
                    if (press) begin
                        state_n = RISE;
                        cnt_n   = '0;
                        inc     = 1'b1;
                    end
                end
                RISE: begin
                    if (tick && cnt == J_LAST) begin
                        state_n = COOL;
                        cnt_n   = '0;
`ifdef JUMP_GEN_DOUBLE_JUMP_EN
                    end else if (press && !dbl) begin
                        cnt_n = '0;
                        dbl_n = 1'b1;
                        inc   = 1'b1;
`endif
                    end else if (tick) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                COOL: begin
                    if (tick && cnt == C_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (tick) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            jump     <= 1'b0;
            busy     <= 1'b0;
            jump_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            jump  <= (state_n == RISE);
            busy  <= (state_n != IDLE);
            if (inc && jump_cnt != 8'hFF)
                jump_cnt <= jump_cnt + 8'd1;
        end
    end

endmodule
